// File: rtl/adc_spi_reader_pkg.sv
// Shared types and frame-geometry helpers for the ADC SPI reader.
package adc_spi_reader_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  function automatic int frame_bits(input int width);
    return width + 3;
  endfunction

  // Clocks from the start tick to the adc_valid pulse.
  function automatic int frame_latency(input int width, input int clk_div);
    return clk_div * (2 * frame_bits(width) + 2) + 1;
  endfunction

  localparam int ADC_WIDTH_DEFAULT = 10;
  localparam int FRAME_BITS        = frame_bits(ADC_WIDTH_DEFAULT);
  localparam int NULL_BIT_IDX      = 2;

endpackage

// File: rtl/adc_spi_reader_sync.sv
// Two-stage synchroniser for asynchronous inputs; cleared to 0 by aclr.
module sync_ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             aclr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_spi_reader.sv
// SPI mode-0 master for an MCP3001-style ADC: periodic conversion, null-bit
// checking, one-cycle adc_valid per frame and a sticky fault after repeated errors.
module adc_spi_reader #(
  parameter int ADC_WIDTH = 10,
  parameter int CLK_DIV   = 8,
  parameter int PERIOD    = 7600,
  parameter int ERR_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 sclr,
  input  logic                 ena,
  output logic                 spi_cs_n,
  output logic                 spi_sck,
  input  logic                 spi_miso,
  output logic [ADC_WIDTH-1:0] adc,
  output logic                 adc_valid,
  output logic                 adc_err,
  output logic                 adc_fault
);

  import adc_spi_reader_pkg::*;

  localparam int FBITS = frame_bits(ADC_WIDTH);
  localparam int TW    = $clog2(PERIOD);
  localparam int BW    = $clog2(FBITS);
  localparam int DW    = 8;
  localparam int EW    = 4;

  logic                 miso_s;
  logic [TW-1:0]        timer;
  logic                 tick;

  state_t               state, state_n;
  logic [DW-1:0]        div_cnt, div_n;
  logic [BW-1:0]        bit_idx, bit_n;
  logic                 phase, phase_n;
  logic [ADC_WIDTH-1:0] shreg, sh_n;
  logic                 null_q, null_n;
  logic                 cs_n_n, sck_n;
  logic                 done;
  logic                 last_div;
  logic [EW-1:0]        err_cnt;

  sync_ff #(.WIDTH(1)) u_sync (
    .clk  (clk),
    .aclr (aclr),
    .d    (spi_miso),
    .q    (miso_s)
  );

  // tick is registered so the count-0 cycle right after a clear does not
  // fire; the first frame after reset starts one full PERIOD later.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      timer <= '0;
      tick  <= 1'b0;
    end else if (sclr) begin
      timer <= '0;
      tick  <= 1'b0;
    end else begin
      tick  <= (timer == TW'(PERIOD - 1));
      timer <= (timer == TW'(PERIOD - 1)) ? '0 : timer + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_idx  <= '0;
      phase    <= 1'b0;
      shreg    <= '0;
      null_q   <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
    end else if (sclr) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_idx  <= '0;
      phase    <= 1'b0;
      shreg    <= '0;
      null_q   <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      bit_idx  <= bit_n;
      phase    <= phase_n;
      shreg    <= sh_n;
      null_q   <= null_n;
      spi_cs_n <= cs_n_n;
      spi_sck  <= sck_n;
    end
  end

  assign last_div = (div_cnt == DW'(CLK_DIV - 1));

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_idx;
    phase_n = phase;
    sh_n    = shreg;
    null_n  = null_q;
    done    = 1'b0;
    case (state)
      IDLE: begin
        div_n   = '0;
        bit_n   = '0;
        phase_n = 1'b0;
        sh_n    = '0;
        null_n  = 1'b0;
        if (tick && ena) state_n = SETUP;
      end
      SETUP: begin
        if (last_div) begin
          div_n   = '0;
          state_n = SHIFT;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      SHIFT: begin
        if (!last_div) begin
          div_n = div_cnt + DW'(1);
        end else begin
          div_n = '0;
          if (!phase) begin
            phase_n = 1'b1;
          end else begin
            // Last clk of the high half: sample, then drop SCK.
            phase_n = 1'b0;
            if (bit_idx == BW'(NULL_BIT_IDX))
              null_n = miso_s;
            else if (bit_idx > BW'(NULL_BIT_IDX))
              sh_n = {shreg[ADC_WIDTH-2:0], miso_s};
            if (bit_idx == BW'(FBITS - 1))
              state_n = HOLD;
            else
              bit_n = bit_idx + BW'(1);
          end
        end
      end
      HOLD: begin
        if (last_div) begin
          div_n   = '0;
          state_n = IDLE;
          done    = 1'b1;
        end else begin
          div_n = div_cnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    cs_n_n = (state_n == IDLE);
    sck_n  = (state_n == SHIFT) && phase_n;
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      adc       <= '0;
      adc_valid <= 1'b0;
      adc_err   <= 1'b0;
      adc_fault <= 1'b0;
      err_cnt   <= '0;
    end else if (sclr) begin
      adc       <= '0;
      adc_valid <= 1'b0;
      adc_err   <= 1'b0;
      adc_fault <= 1'b0;
      err_cnt   <= '0;
    end else begin
      adc_valid <= done;
      if (done) begin
        adc     <= shreg;
        adc_err <= null_q;
        if (null_q) begin
          if (err_cnt != EW'(ERR_LIMIT)) err_cnt <= err_cnt + EW'(1);
          if (err_cnt >= EW'(ERR_LIMIT - 1)) adc_fault <= 1'b1;
        end else begin
          err_cnt <= '0;
        end
      end
    end
  end

  tick_outside_idle: assert property (@(posedge clk) disable iff (aclr || sclr)
    !(tick && state != IDLE));

endmodule

// File: tb/tb_adc_spi_reader.sv
// Directed bench for adc_spi_reader with a behavioural MCP3001-style ADC model.
module tb_adc_spi_reader;

  localparam int PERIOD = 1600;

  logic       clk = 1'b0;
  logic       aclr = 1'b1;
  logic       sclr = 1'b0;
  logic       ena = 1'b0;
  logic       spi_cs_n, spi_sck;
  logic       spi_miso = 1'b0;
  logic [9:0] adc;
  logic       adc_valid, adc_err, adc_fault;

  adc_spi_reader #(.ADC_WIDTH(10), .CLK_DIV(8), .PERIOD(PERIOD), .ERR_LIMIT(4)) dut (
    .clk       (clk),
    .aclr      (aclr),
    .sclr      (sclr),
    .ena       (ena),
    .spi_cs_n  (spi_cs_n),
    .spi_sck   (spi_sck),
    .spi_miso  (spi_miso),
    .adc       (adc),
    .adc_valid (adc_valid),
    .adc_err   (adc_err),
    .adc_fault (adc_fault)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ADC model: bit k is presented from the (k)th SCK fall (bit 0 at CS fall).
  logic [9:0] model_code = 10'h000;
  logic       model_null = 1'b0;
  int         mbit = 0;
  logic       m_cs = 1'b1, m_sck = 1'b0;
  always @(spi_cs_n or spi_sck) begin
    if (m_cs && !spi_cs_n) mbit = 0;
    else if (m_sck && !spi_sck && !spi_cs_n) mbit = mbit + 1;
    m_cs = spi_cs_n;
    m_sck = spi_sck;
    if (mbit < 2) spi_miso = 1'b1;
    else if (mbit == 2) spi_miso = model_null;
    else if (mbit <= 12) spi_miso = model_code[12 - mbit];
    else spi_miso = 1'b0;
  end

  // Bus monitor, sampled on the falling clk edge.
  int cs_falls = 0, cs_fall_t = 0, cs_rise_t = 0, cs_low_len = 0, last_gap = 0;
  int rises = 0, last_rises = 0, first_rise_off = 0, last_edge_t = 0, half_bad = 0;
  int vcount = 0, wide = 0;
  int v_time [0:63];
  logic [9:0] v_adc = '0;
  logic v_err = 1'b0, v_fault = 1'b0;
  logic p_cs = 1'b1, p_sck = 1'b0, p_valid = 1'b0;
  always @(negedge clk) begin
    if (p_cs && !spi_cs_n) begin
      cs_falls++;
      last_gap = cyc - cs_rise_t;
      cs_fall_t = cyc;
      rises = 0;
      last_edge_t = cyc;
    end
    if (!p_cs && spi_cs_n) begin
      cs_rise_t = cyc;
      cs_low_len = cyc - cs_fall_t;
      last_rises = rises;
    end
    if (!p_sck && spi_sck) begin
      rises++;
      if (rises == 1) first_rise_off = cyc - cs_fall_t;
      else if (cyc - last_edge_t != 8) half_bad++;
      last_edge_t = cyc;
    end
    if (p_sck && !spi_sck && !spi_cs_n) begin
      if (cyc - last_edge_t != 8) half_bad++;
      last_edge_t = cyc;
    end
    if (adc_valid) begin
      if (p_valid) wide++;
      if (vcount < 64) v_time[vcount] = cyc;
      vcount++;
      v_adc = adc;
      v_err = adc_err;
      v_fault = adc_fault;
    end
    p_cs = spi_cs_n;
    p_sck = spi_sck;
    p_valid = adc_valid;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) step();
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step();
  endtask

  task automatic wait_valid(input int n, input string tag);
    int k = 0;
    while (vcount < n && k < 2 * PERIOD + 400) begin
      step();
      k++;
    end
    check({tag, "_timeout"}, 32'(vcount >= n), 1);
  endtask

  task automatic wait_fall(input int n, input string tag);
    int k = 0;
    while (cs_falls < n && k < 2 * PERIOD + 400) begin
      step();
      k++;
    end
    check({tag, "_timeout"}, 32'(cs_falls >= n), 1);
  endtask

  task automatic do_frame(input int n, input logic [9:0] code, input logic nul,
                          input logic exp_fault, input string tag);
    model_code = code;
    model_null = nul;
    wait_valid(n, tag);
    check({tag, "_adc"}, v_adc, code);
    check({tag, "_err"}, v_err, nul);
    check({tag, "_fault"}, v_fault, exp_fault);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cs_n"}, spi_cs_n, 1);
    check({tag, "_sck"}, spi_sck, 0);
    check({tag, "_adc"}, adc, 0);
    check({tag, "_valid"}, adc_valid, 0);
    check({tag, "_err"}, adc_err, 0);
    check({tag, "_fault"}, adc_fault, 0);
  endtask

  int r, rel, f, nfalls;

  initial begin
    // Reset values while aclr is held.
    wait_cyc(4);
    check_reset("rst");

    // Nominal frame.
    model_code = 10'h2A5;
    model_null = 1'b0;
    ena = 1'b1;
    @(negedge clk);
    aclr = 1'b0;
    r = cyc;
    wait_valid(1, "nom");
    check("nom_adc", v_adc, 10'h2A5);
    check("nom_err", v_err, 0);
    check("nom_fault", v_fault, 0);
    check("nom_start", cs_fall_t - r, PERIOD + 1);
    check("nom_latency", v_time[0] - (cs_fall_t - 1), 225);
    wait_cyc(2);
    check("nom_cs_low", cs_low_len, 224);
    check("nom_sck_rises", last_rises, 13);
    check("nom_first_rise", first_rise_off, 16);
    check("nom_half_len", half_bad, 0);

    // Rate, including all-zeros and all-ones codes.
    do_frame(2, 10'h000, 1'b0, 1'b0, "rate2");
    do_frame(3, 10'h3FF, 1'b0, 1'b0, "rate3");
    do_frame(4, 10'h155, 1'b0, 1'b0, "rate4");
    do_frame(5, 10'h2AA, 1'b0, 1'b0, "rate5");
    for (int i = 1; i < 5; i++) check("rate_spacing", v_time[i] - v_time[i-1], PERIOD);
    check("rate_cs_gap", last_gap, PERIOD - 224);
    check("rate_sck_rises", last_rises, 13);

    // Null-bit errors: fault on the 4th, sticky afterwards.
    do_frame(6, 10'h3FF, 1'b1, 1'b0, "nerr1");
    do_frame(7, 10'h3FF, 1'b1, 1'b0, "nerr2");
    do_frame(8, 10'h3FF, 1'b1, 1'b0, "nerr3");
    do_frame(9, 10'h3FF, 1'b1, 1'b1, "nerr4");
    do_frame(10, 10'h123, 1'b0, 1'b1, "nerr_good");

    // sclr between frames clears fault and outputs.
    step();
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    check("sclr_fault", adc_fault, 0);
    check("sclr_adc", adc, 0);
    check("sclr_err", adc_err, 0);

    // Error counter cleared by a good frame.
    do_frame(11, 10'h111, 1'b1, 1'b0, "clr1");
    do_frame(12, 10'h222, 1'b1, 1'b0, "clr2");
    do_frame(13, 10'h333, 1'b0, 1'b0, "clr3");
    do_frame(14, 10'h044, 1'b1, 1'b0, "clr4");
    do_frame(15, 10'h055, 1'b1, 1'b0, "clr5");
    do_frame(16, 10'h066, 1'b1, 1'b0, "clr6");

    // sclr mid-frame at tick+100.
    model_code = 10'h1AB;
    model_null = 1'b0;
    nfalls = cs_falls + 1;
    wait_fall(nfalls, "abort_start");
    wait_until(cs_fall_t + 99);
    sclr = 1'b1;
    step();
    sclr = 1'b0;
    rel = cyc;
    check("abort_cs_n", spi_cs_n, 1);
    check("abort_sck", spi_sck, 0);
    model_code = 10'h0F0;
    model_null = 1'b1;
    wait_fall(nfalls + 1, "abort_next");
    check("abort_no_valid", vcount, 16);
    check("abort_restart", cs_fall_t - rel, PERIOD + 1);
    wait_valid(17, "after_abort");
    check("after_abort_adc", v_adc, 10'h0F0);
    check("after_abort_err", v_err, 1);

    // aclr between edges, mid-SHIFT while SCK is high.
    model_code = 10'h155;
    model_null = 1'b0;
    wait_fall(nfalls + 2, "aclr_start");
    f = cs_fall_t;
    wait_until(f + 18);
    check("aclr_pre_sck", spi_sck, 1);
    #1 aclr = 1'b1;
    #1 check_reset("aclr");
    wait_cyc(3);
    @(negedge clk);
    aclr = 1'b0;
    #1;

    // ena low at tick: no activity for more than one period.
    ena = 1'b0;
    nfalls = cs_falls;
    wait_cyc(PERIOD + 300);
    check("ena0_no_cs", cs_falls, nfalls);
    check("ena0_no_valid", vcount, 17);

    // ena dropped mid-frame still completes the frame.
    ena = 1'b1;
    model_code = 10'h3C3;
    model_null = 1'b0;
    wait_fall(nfalls + 1, "enadrop_start");
    wait_cyc(30);
    ena = 1'b0;
    wait_valid(18, "enadrop");
    check("enadrop_adc", v_adc, 10'h3C3);
    check("enadrop_err", v_err, 0);
    wait_cyc(4);
    check("valid_single_cycle", wide, 0);
    check("half_len_all", half_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
